// File: rtl/ulpi_capture_framer.sv
// ulpi_capture_framer
// Groups USB bytes received from the ULPI link into packets (delimited by the
// RxActive bit of RXCMD bytes), buffers each packet whole and then emits one
// record per packet: a 7-byte header (magic, flags, length, timestamp)
// followed by the payload. Packets that cannot be queued are dropped and
// counted, and the next record's header carries a "lost" flag.
module ulpi_capture_framer #(
   parameter int         BUF_AW  = 11,
   parameter int         HDR_AW  = 4,
   parameter int         MAX_LEN = 1024,
   parameter logic [7:0] MAGIC   = 8'hA0
) (
   input  logic       CLK,
   input  logic       RST,
   input  logic [7:0] DATA,
   input  logic       RXCMD,
   input  logic       VALID,
   output logic [7:0] OUT_DATA,
   output logic       OUT_WR,
   input  logic       OUT_HAVE_SPACE,
   output logic [7:0] STAT_DROPS,
   output logic       PKT_ACTIVE
);

   localparam int LEN_W     = 11;
   localparam int HDR_W     = LEN_W + 24 + 3;
   localparam int BUF_DEPTH = 1 << BUF_AW;
   localparam int HDR_DEPTH = 1 << HDR_AW;

   localparam logic [LEN_W-1:0]  MAX_LEN_V  = LEN_W'(MAX_LEN);
   localparam logic [BUF_AW:0]   BUF_FULL_N = (BUF_AW+1)'(BUF_DEPTH);
   localparam logic [HDR_AW:0]   HDR_FULL_N = (HDR_AW+1)'(HDR_DEPTH);

   typedef enum logic {C_IDLE, C_PKT} cap_state_t;
   typedef enum logic [1:0] {E_IDLE, E_HDR, E_PAY} emit_state_t;

   // timestamp
   logic [23:0] ts_cnt;

   // capture side
   cap_state_t       cap_state, cap_next;
   logic [BUF_AW:0]  wr_ptr, start_ptr, rd_ptr, buf_used;
   logic [LEN_W-1:0] cur_len;
   logic [23:0]      cur_ts;
   logic             cur_err, cur_trunc, lost;
   logic [7:0]       drops;
   logic             buf_full, buf_we, start_pkt, set_trunc, set_err, end_pkt;
   logic             hdr_push, pkt_drop;
   logic             rx_active, rx_error, is_cmd, is_data;

   // storage
   logic [7:0]       buf_mem [BUF_DEPTH];
   logic [HDR_W-1:0] hdr_mem [HDR_DEPTH];
   logic [HDR_AW:0]  hdr_wr, hdr_rd, hdr_count;
   logic             hdr_full, hdr_empty, hdr_pop;

   // emit side
   emit_state_t      emit_state, emit_next;
   logic [2:0]       hdr_idx, idx_next;
   logic [LEN_W-1:0] pay_cnt, cnt_next;
   logic             issue, rd_adv;
   logic [7:0]       issue_byte, hdr_byte;
   logic [HDR_W-1:0] head;
   logic [LEN_W-1:0] head_len;
   logic [23:0]      head_ts;
   logic [7:0]       head_flags;

   assign rx_active = DATA[4];
   assign rx_error  = (DATA[5:4] == 2'b11);
   assign is_cmd    = VALID & RXCMD;
   assign is_data   = VALID & ~RXCMD;

   assign buf_used  = wr_ptr - rd_ptr;
   assign buf_full  = (buf_used == BUF_FULL_N);
   assign hdr_count = hdr_wr - hdr_rd;
   assign hdr_full  = (hdr_count == HDR_FULL_N);
   assign hdr_empty = (hdr_wr == hdr_rd);

   assign hdr_push  = end_pkt && (cur_len != '0) && !hdr_full;
   assign pkt_drop  = end_pkt && (cur_len != '0) && hdr_full;

   assign head       = hdr_mem[hdr_rd[HDR_AW-1:0]];
   assign head_len   = head[HDR_W-1 -: LEN_W];
   assign head_ts    = head[26:3];
   assign head_flags = {5'b0, head[0], head[1], head[2]};

   assign STAT_DROPS = drops;
   assign PKT_ACTIVE = (cap_state == C_PKT);

   // Free-running timestamp, one tick per clock
   always_ff @(posedge CLK) begin
      if (RST) ts_cnt <= '0;
      else     ts_cnt <= ts_cnt + 24'd1;
   end

   // Capture FSM: decide what to do with the incoming byte
   always_comb begin
      cap_next  = cap_state;
      start_pkt = 1'b0;
      buf_we    = 1'b0;
      set_trunc = 1'b0;
      set_err   = 1'b0;
      end_pkt   = 1'b0;
      case (cap_state)
         C_IDLE: begin
            if (is_cmd && rx_active) begin
               cap_next  = C_PKT;
               start_pkt = 1'b1;
            end
         end
         C_PKT: begin
            if (is_data) begin
               if ((cur_len < MAX_LEN_V) && !buf_full) buf_we = 1'b1;
               else                                      set_trunc = 1'b1;
            end else if (is_cmd) begin
               if (!rx_active) begin
                  cap_next = C_IDLE;
                  end_pkt  = 1'b1;
               end else if (rx_error) begin
                  set_err = 1'b1;
               end
            end
         end
         default: cap_next = C_IDLE;
      endcase
   end

   // Capture state, per-packet bookkeeping, write pointer rollback and drop count
   always_ff @(posedge CLK) begin
      if (RST) begin
         cap_state <= C_IDLE;
         wr_ptr    <= '0;
         start_ptr <= '0;
         cur_len   <= '0;
         cur_ts    <= '0;
         cur_err   <= 1'b0;
         cur_trunc <= 1'b0;
         lost      <= 1'b0;
         drops     <= '0;
      end else begin
         cap_state <= cap_next;
         if (start_pkt) begin
            cur_ts    <= ts_cnt;
            start_ptr <= wr_ptr;
            cur_len   <= '0;
            cur_err   <= rx_error;
            cur_trunc <= 1'b0;
         end
         if (buf_we) begin
            wr_ptr  <= wr_ptr + (BUF_AW+1)'(1);
            cur_len <= cur_len + LEN_W'(1);
         end
         if (set_trunc) cur_trunc <= 1'b1;
         if (set_err)   cur_err   <= 1'b1;
         if (pkt_drop) begin
            wr_ptr <= start_ptr;
            lost   <= 1'b1;
            if (drops != 8'hFF) drops <= drops + 8'd1;
         end
         if (hdr_push) lost <= 1'b0;
      end
   end

   // Payload buffer write port (contents need no reset, pointers guard them)
   always_ff @(posedge CLK) begin
      if (buf_we) buf_mem[wr_ptr[BUF_AW-1:0]] <= DATA;
   end

   // Header FIFO storage: {len, ts, err, trunc, lost}
   always_ff @(posedge CLK) begin
      if (hdr_push) hdr_mem[hdr_wr[HDR_AW-1:0]] <= {cur_len, cur_ts, cur_err, cur_trunc, lost};
   end

   // Header FIFO pointers; push and pop may happen together
   always_ff @(posedge CLK) begin
      if (RST) begin
         hdr_wr <= '0;
         hdr_rd <= '0;
      end else begin
         if (hdr_push) hdr_wr <= hdr_wr + (HDR_AW+1)'(1);
         if (hdr_pop)  hdr_rd <= hdr_rd + (HDR_AW+1)'(1);
      end
   end

   // Select the header byte for the current header position
   always_comb begin
      hdr_byte = 8'h00;
      case (hdr_idx)
         3'd0: hdr_byte = MAGIC;
         3'd1: hdr_byte = head_flags;
         3'd2: hdr_byte = head_len[7:0];
         3'd3: hdr_byte = {5'b0, head_len[10:8]};
         3'd4: hdr_byte = head_ts[7:0];
         3'd5: hdr_byte = head_ts[15:8];
         3'd6: hdr_byte = head_ts[23:16];
         default: hdr_byte = 8'h00;
      endcase
   end

   // Emit FSM: walk header then payload, one byte per cycle the sink has room
   always_comb begin
      emit_next  = emit_state;
      idx_next   = hdr_idx;
      cnt_next   = pay_cnt;
      issue      = 1'b0;
      issue_byte = 8'h00;
      rd_adv     = 1'b0;
      hdr_pop    = 1'b0;
      case (emit_state)
         E_IDLE: begin
            if (!hdr_empty) begin
               emit_next = E_HDR;
               if (OUT_HAVE_SPACE) begin
                  issue      = 1'b1;
                  issue_byte = MAGIC;
                  idx_next   = 3'd1;
               end else begin
                  idx_next   = 3'd0;
               end
            end
         end
         E_HDR: begin
            if (OUT_HAVE_SPACE) begin
               issue      = 1'b1;
               issue_byte = hdr_byte;
               if (hdr_idx == 3'd6) begin
                  emit_next = E_PAY;
                  cnt_next  = '0;
               end else begin
                  idx_next  = hdr_idx + 3'd1;
               end
            end
         end
         E_PAY: begin
            if (OUT_HAVE_SPACE) begin
               issue      = 1'b1;
               issue_byte = buf_mem[rd_ptr[BUF_AW-1:0]];
               rd_adv     = 1'b1;
               cnt_next   = pay_cnt + LEN_W'(1);
               if (pay_cnt == head_len - LEN_W'(1)) begin
                  hdr_pop = 1'b1;
                  if (hdr_count > (HDR_AW+1)'(1)) begin
                     emit_next = E_HDR;
                     idx_next  = 3'd0;
                  end else begin
                     emit_next = E_IDLE;
                  end
               end
            end
         end
         default: emit_next = E_IDLE;
      endcase
   end

   // Emit state, read pointer and registered output byte/strobe
   always_ff @(posedge CLK) begin
      if (RST) begin
         emit_state <= E_IDLE;
         hdr_idx    <= '0;
         pay_cnt    <= '0;
         rd_ptr     <= '0;
         OUT_WR     <= 1'b0;
         OUT_DATA   <= 8'h00;
      end else begin
         emit_state <= emit_next;
         hdr_idx    <= idx_next;
         pay_cnt    <= cnt_next;
         if (rd_adv) rd_ptr <= rd_ptr + (BUF_AW+1)'(1);
         OUT_WR <= issue;
         if (issue) OUT_DATA <= issue_byte;
      end
   end

endmodule

// File: tb/tb_ulpi_capture_framer.sv
// Testbench for ulpi_capture_framer. Stimulus tasks push the expected record
// bytes into a queue; a separate monitor pops and compares every OUT_WR byte.
// A small buffer (32 bytes) and MAX_LEN of 20 let wrap, buffer-full and
// truncation cases happen with short packets.
module tb_ulpi_capture_framer;

   localparam int MAX_LEN = 20;

   logic       CLK = 1'b0;
   logic       RST = 1'b1;
   logic [7:0] DATA = 8'h00;
   logic       RXCMD = 1'b0;
   logic       VALID = 1'b0;
   logic [7:0] OUT_DATA;
   logic       OUT_WR;
   logic       OUT_HAVE_SPACE = 1'b1;
   logic [7:0] STAT_DROPS;
   logic       PKT_ACTIVE;

   int         n_checks = 0;
   int         n_fails = 0;
   int         wr_pulses = 0;
   logic [7:0] exp_q[$];
   logic [23:0] tb_cyc;
   logic       space_q;

   ulpi_capture_framer #(
      .BUF_AW(5),
      .HDR_AW(4),
      .MAX_LEN(MAX_LEN),
      .MAGIC(8'hA0)
   ) dut (
      .CLK(CLK),
      .RST(RST),
      .DATA(DATA),
      .RXCMD(RXCMD),
      .VALID(VALID),
      .OUT_DATA(OUT_DATA),
      .OUT_WR(OUT_WR),
      .OUT_HAVE_SPACE(OUT_HAVE_SPACE),
      .STAT_DROPS(STAT_DROPS),
      .PKT_ACTIVE(PKT_ACTIVE)
   );

   // 100 MHz clock
   always #5 CLK = ~CLK;

   // Reference cycle count: what the timestamp counter should read
   always @(posedge CLK) begin
      if (RST) tb_cyc <= '0;
      else     tb_cyc <= tb_cyc + 24'd1;
   end

   // Remember the sink's room as seen at each clock edge
   always @(posedge CLK) space_q <= OUT_HAVE_SPACE;

   // Watchdog so the run always ends
   initial begin
      #400000;
      $display("[TB] FAIL watchdog: got timeout expected finish");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic check_output(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fails++;
         $display("[TB] FAIL %s: got %0h expected %0h", name, got, exp);
      end
   endtask

   // Monitor: every written byte must be next in the scoreboard
   always @(posedge CLK) begin
      logic [7:0] exp_b;
      #1;
      if (OUT_WR === 1'b1) begin
         wr_pulses++;
         check_output("wr_after_space_low", 32'(space_q), 32'd1);
         if (exp_q.size() == 0) begin
            n_checks++;
            n_fails++;
            $display("[TB] FAIL out_unexpected: got %h expected none", OUT_DATA);
         end else begin
            exp_b = exp_q.pop_front();
            check_output("out_byte", 32'(OUT_DATA), 32'(exp_b));
         end
      end
   end

   task automatic expect_record(input logic [7:0] flags, input int len, input logic [23:0] ts,
                                input logic [7:0] base);
      logic [10:0] l;
      l = 11'(len);
      exp_q.push_back(8'hA0);
      exp_q.push_back(flags);
      exp_q.push_back(l[7:0]);
      exp_q.push_back({5'b0, l[10:8]});
      exp_q.push_back(ts[7:0]);
      exp_q.push_back(ts[15:8]);
      exp_q.push_back(ts[23:16]);
      for (int i = 0; i < len; i++) exp_q.push_back(base + 8'(i));
   endtask

   // Drive one packet: RXCMD start, optional error RXCMD, data bytes, RXCMD end
   task automatic apply_stimulus(input int n_data, input logic [7:0] base, input bit err_cmd,
                                 input bit want, input logic [7:0] exp_flags, input int exp_len);
      logic [23:0] ts;
      @(negedge CLK);
      VALID = 1'b1;
      RXCMD = 1'b1;
      DATA  = 8'h10;
      ts    = tb_cyc;
      if (want) expect_record(exp_flags, exp_len, ts, base);
      if (err_cmd) begin
         @(negedge CLK);
         DATA = 8'h30;
      end
      for (int i = 0; i < n_data; i++) begin
         @(negedge CLK);
         RXCMD = 1'b0;
         DATA  = base + 8'(i);
      end
      @(negedge CLK);
      RXCMD = 1'b1;
      DATA  = 8'h00;
      @(negedge CLK);
      VALID = 1'b0;
      RXCMD = 1'b0;
      DATA  = 8'h00;
   endtask

   task automatic wait_drain(input int budget);
      for (int i = 0; i < budget && exp_q.size() != 0; i++) @(negedge CLK);
      repeat (4) @(negedge CLK);
      check_output("drain_left", 32'(exp_q.size()), 32'd0);
   endtask

   // Directed test sequence
   initial begin
      repeat (3) @(negedge CLK);
      check_output("rst_out_wr", 32'(OUT_WR), 32'd0);
      check_output("rst_out_data", 32'(OUT_DATA), 32'd0);
      check_output("rst_drops", 32'(STAT_DROPS), 32'd0);
      check_output("rst_pkt_active", 32'(PKT_ACTIVE), 32'd0);
      RST = 1'b0;
      repeat (2) @(negedge CLK);

      $display("[TB] basic three-byte packet");
      apply_stimulus(3, 8'h01, 1'b0, 1'b1, 8'h00, 3);
      @(posedge CLK);
      #1;
      check_output("latency_wr", 32'(OUT_WR), 32'd1);
      check_output("latency_magic", 32'(OUT_DATA), 32'hA0);
      wait_drain(100);

      $display("[TB] rx error packet");
      apply_stimulus(1, 8'hAA, 1'b1, 1'b1, 8'h01, 1);
      wait_drain(100);

      $display("[TB] zero-length packet is silent");
      apply_stimulus(0, 8'h00, 1'b0, 1'b0, 8'h00, 0);
      wait_drain(20);

      $display("[TB] truncation at MAX_LEN");
      apply_stimulus(MAX_LEN + 2, 8'h10, 1'b0, 1'b1, 8'h02, MAX_LEN);
      wait_drain(200);

      $display("[TB] header FIFO overflow");
      @(negedge CLK);
      OUT_HAVE_SPACE = 1'b0;
      for (int k = 0; k < 16; k++) apply_stimulus(1, 8'h40 + 8'(k), 1'b0, 1'b1, 8'h00, 1);
      apply_stimulus(1, 8'h7F, 1'b0, 1'b0, 8'h00, 0);
      check_output("drops_after_overflow", 32'(STAT_DROPS), 32'd1);
      OUT_HAVE_SPACE = 1'b1;
      wait_drain(600);
      apply_stimulus(2, 8'h50, 1'b0, 1'b1, 8'h04, 2);
      wait_drain(100);

      $display("[TB] payload buffer full");
      @(negedge CLK);
      OUT_HAVE_SPACE = 1'b0;
      apply_stimulus(20, 8'h60, 1'b0, 1'b1, 8'h00, 20);
      apply_stimulus(20, 8'h80, 1'b0, 1'b1, 8'h02, 12);
      OUT_HAVE_SPACE = 1'b1;
      wait_drain(300);

      $display("[TB] stalling sink");
      @(negedge CLK);
      OUT_HAVE_SPACE = 1'b0;
      wr_pulses = 0;
      apply_stimulus(20, 8'hC0, 1'b0, 1'b1, 8'h00, 20);
      for (int i = 0; i < 100 && exp_q.size() != 0; i++) begin
         OUT_HAVE_SPACE = ~OUT_HAVE_SPACE;
         repeat (3) @(negedge CLK);
      end
      OUT_HAVE_SPACE = 1'b1;
      wait_drain(20);
      check_output("stall_pulses", 32'(wr_pulses), 32'd27);

      $display("[TB] reset mid-payload");
      apply_stimulus(20, 8'hE0, 1'b0, 1'b1, 8'h00, 20);
      for (int i = 0; i < 100 && exp_q.size() > 12; i++) @(negedge CLK);
      check_output("mid_payload_reached", 32'(exp_q.size() <= 12), 32'd1);
      RST = 1'b1;
      exp_q.delete();
      @(negedge CLK);
      check_output("midrst_out_wr", 32'(OUT_WR), 32'd0);
      check_output("midrst_drops", 32'(STAT_DROPS), 32'd0);
      check_output("midrst_pkt_active", 32'(PKT_ACTIVE), 32'd0);
      RST = 1'b0;
      repeat (2) @(negedge CLK);
      apply_stimulus(3, 8'h21, 1'b0, 1'b1, 8'h00, 3);
      wait_drain(100);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule
